spi_master_fifo: RTL and testbench
==================================

SPI_MASTER_FIFO -- requirements
Module: spi_master_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame width in bits (legal 4..16).
REQ-002 SHALL have parameter NUM_SS, default 1, slave-select line count (legal 1..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, TX and RX FIFO depth in words (power of 2, legal 2..64).
REQ-004 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port chipselect  in  1  register access enable.
REQ-007 SHALL have ports read_n / write_n  in  1 each  active-low read / write strobes, qualified by chipselect.
REQ-008 SHALL have port address  in  3  register select: 0 rxdata(r, pop), 1 txdata(w, push), 2 status(r; any write clears TOE/ROE), 3 control(r/w), 4 clkdiv(r/w), 5 slave-select(r/w), 6 levels(r).
REQ-009 SHALL have ports writedata  in  16 and readdata  out  16  register data.
REQ-010 SHALL have port irq  out  1  registered interrupt.
REQ-011 SHALL have ports sclk  out  1, mosi  out  1, miso  in  1, ss_n  out  NUM_SS (active low).

Function
REQ-012 Reads SHALL return registered readdata one clk after the strobe; a write SHALL take effect on its strobe cycle; each strobe cycle is one access.
REQ-013 Control bits SHALL be: [0] CPOL, [1] CPHA, [2] LSBFIRST, [3] SSO (force slave select), [4] iTXE, [5] iRRDY, [6] iERR; all other bits read 0.
REQ-014 Status bits SHALL be: [0] TXE (TX FIFO empty), [1] TXF (full), [2] RRDY (RX not empty), [3] RXF (full), [4] BUSY, [5] TOE, [6] ROE.
REQ-015 Levels register SHALL read {RX count in [15:8], TX count in [7:0]}, counts 0..FIFO_DEPTH.
REQ-016 A txdata write with TX not full SHALL push writedata[DATA_W-1:0]; a write when full SHALL be dropped and set TOE.
REQ-017 An rxdata read with RX not empty SHALL return and pop the head word, zero-extended; a read when empty SHALL return 0 with no pointer change.
REQ-018 A push and a pop on the same FIFO in the same cycle SHALL both succeed and leave the count unchanged, including at full and empty.
REQ-019 The sclk half-period SHALL be clkdiv[7:0]+1 clk cycles (clkdiv=0 gives clk/2).
REQ-020 The transfer FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-021 IDLE->SETUP SHALL occur when TX is not empty; it SHALL pop one word and latch CPOL/CPHA/LSBFIRST/clkdiv for the whole frame.
REQ-022 SETUP SHALL last one half-period with the selected ss_n asserted and the first bit on mosi, then go to SHIFT.
REQ-023 SHIFT SHALL produce exactly 2*DATA_W sclk edges; in CPHA=0, sample miso on leading edges and change mosi on trailing edges; in CPHA=1, change on leading and sample on trailing edges.
REQ-024 HOLD SHALL last one half-period, then push the received word to RX, or, if RX is full, drop it and set ROE.
REQ-025 After HOLD, if SSO=1 and TX is not empty, the FSM SHALL go directly to SETUP with ss_n held asserted; otherwise it SHALL go to GAP.
REQ-026 GAP SHALL deassert ss_n for one half-period, then go to IDLE.
REQ-027 sclk SHALL equal CPOL whenever the FSM is not in SHIFT.
REQ-028 ss_n[i] SHALL be low iff slave-select bit i = 1 and (the state is SETUP, SHIFT or HOLD, or SSO = 1).
REQ-029 Writes to control, clkdiv or slave-select during BUSY SHALL update the register immediately but SHALL affect only the next frame; slave-select takes effect on ss_n immediately only when SSO = 1.
REQ-030 BUSY SHALL be 1 in all states other than IDLE.
REQ-031 irq SHALL be registered as (TXE&iTXE)|(RRDY&iRRDY)|((TOE|ROE)&iERR).

Reset
REQ-032 On reset_n low, asynchronously: FSM=IDLE, both FIFOs empty, TOE=ROE=0, control=0, clkdiv=0, slave-select=1, sclk=0, mosi=0, ss_n all 1, irq=0, readdata=0.
REQ-033 Reset mid-frame SHALL abort the frame without pushing to RX; after release, the first edges SHALL follow the reset CPOL=0.

Verification
REQ-034 Mode 0, clkdiv=1, DATA_W=8, push 0xA5 with miso looped to mosi -> 8 sclk pulses of period 4 clk, MSB first, RX=0xA5, RRDY=1.
REQ-035 For each CPOL/CPHA combination and LSBFIRST=1, push 0x3C with miso driven by a slave model returning 0xC3 -> correct edge alignment and rxdata=0xC3.
REQ-036 FIFO_DEPTH=8: push 9 words while the link is idle-blocked (clkdiv=255) -> TX count 8, TOE=1, irq=1 with iERR=1; a status write -> TOE=0.
REQ-037 Leave RX unread for 9 frames -> RX count 8, ROE=1, first 8 words preserved in order.
REQ-038 SSO=1, push 3 words -> ss_n stays low across all 3 frames; SSO=0 -> a 1-half-period ss_n high gap between frames.
REQ-039 Assert reset_n in mid-SHIFT -> ss_n=all 1s and sclk=0 at once, RX count 0, TX count 0.

Source files
------------

// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX word FIFOs behind a small register bus.
// One frame per TX word; mode, bit order and divider latched per frame.
module spi_master_fifo #(
    parameter int DATA_W     = 8,
    parameter int NUM_SS     = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [2:0]        address,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t state, state_d;

    logic [6:0]        ctrl;
    logic [7:0]        clkdiv;
    logic [NUM_SS-1:0] ss_reg;
    logic              toe, roe;

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0]     tx_cnt, rx_cnt;

    logic              cpol_l, cpha_l, lsb_l, sclk_q;
    logic [7:0]        div_l, div_cnt;
    logic [NUM_SS-1:0] ss_l;
    logic [DATA_W-1:0] sh, rx_sh;
    logic [EW-1:0]     edge_cnt;

    logic wr, rd, tx_wr, rx_rd;
    logic tx_pop, tx_push, rx_pop, rx_push, rx_push_req, start;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tick, leading, sample, advance, busy, frame_act;
    logic [15:0] status, rd_mux;
    logic unused_wd;

    assign wr       = chipselect & ~write_n;
    assign rd       = chipselect & ~read_n;
    assign tx_wr    = wr && address == 3'd1;
    assign rx_rd    = rd && address == 3'd0;
    assign tx_empty = tx_cnt == '0;
    assign tx_full  = tx_cnt == FULL_CNT;
    assign rx_empty = rx_cnt == '0;
    assign rx_full  = rx_cnt == FULL_CNT;
    // A full FIFO still accepts a push when it is popped in the same cycle
    assign tx_push  = tx_wr && (!tx_full || tx_pop);
    assign rx_pop   = rx_rd && !rx_empty;
    assign rx_push  = rx_push_req && (!rx_full || rx_pop);

    assign tick      = div_cnt == div_l;
    assign leading   = ~edge_cnt[0];
    assign sample    = leading ^ cpha_l;
    // First bit is already on mosi from SETUP, so skip the first/last change
    assign advance   = cpha_l ? (leading && edge_cnt != '0)
                              : (!leading && edge_cnt != LAST_EDGE);
    assign busy      = state != IDLE;
    assign frame_act = state == SETUP || state == SHIFT || state == HOLD;
    assign status    = {9'b0, roe, toe, busy, rx_full, ~rx_empty,
                        tx_full, tx_empty};
    assign unused_wd = ^writedata;

    assign sclk = sclk_q;
    assign mosi = (state == IDLE) ? 1'b0 : (lsb_l ? sh[0] : sh[DATA_W-1]);
    assign ss_n = ~((ss_l & {NUM_SS{frame_act}}) |
                    (ss_reg & {NUM_SS{ctrl[3]}}));

    // Transfer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next-state logic, frame start and RX push request
    always_comb begin
        state_d     = state;
        tx_pop      = 1'b0;
        start       = 1'b0;
        rx_push_req = 1'b0;
        unique case (state)
            IDLE: if (!tx_empty) begin
                tx_pop  = 1'b1;
                start   = 1'b1;
                state_d = SETUP;
            end
            SETUP: if (tick) state_d = SHIFT;
            SHIFT: if (tick && edge_cnt == LAST_EDGE) state_d = HOLD;
            HOLD: if (tick) begin
                rx_push_req = 1'b1;
                if (ctrl[3] && !tx_empty) begin
                    tx_pop  = 1'b1;
                    start   = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath: per-frame latches, divider, sclk and shift registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
            div_l    <= '0;
            ss_l     <= '0;
            sh       <= '0;
            rx_sh    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk_q   <= 1'b0;
        end else if (start) begin
            cpol_l   <= ctrl[0];
            cpha_l   <= ctrl[1];
            lsb_l    <= ctrl[2];
            div_l    <= clkdiv;
            ss_l     <= ss_reg;
            sh       <= tx_mem[tx_rp];
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk_q   <= ctrl[0];
        end else begin
            div_cnt <= (state == IDLE || tick) ? 8'd0 : div_cnt + 8'd1;
            if (state == IDLE) sclk_q <= ctrl[0];
            if (state == SHIFT && tick) begin
                sclk_q   <= ~sclk_q;
                edge_cnt <= edge_cnt + EW'(1);
                if (sample)
                    rx_sh <= lsb_l ? {miso, rx_sh[DATA_W-1:1]}
                                   : {rx_sh[DATA_W-2:0], miso};
                if (advance)
                    sh <= lsb_l ? (sh >> 1) : (sh << 1);
            end
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= writedata[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    // Register read mux
    always_comb begin
        rd_mux = '0;
        unique case (address)
            3'd0: if (!rx_empty) rd_mux = 16'(rx_mem[rx_rp]);
            3'd2: rd_mux = status;
            3'd3: rd_mux = {9'b0, ctrl};
            3'd4: rd_mux = {8'b0, clkdiv};
            3'd5: rd_mux = 16'(ss_reg);
            3'd6: rd_mux = {8'(rx_cnt), 8'(tx_cnt)};
            default: rd_mux = '0;
        endcase
    end

    // Config registers, error flags, interrupt and read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= '0;
            clkdiv   <= '0;
            ss_reg   <= NUM_SS'(1);
            toe      <= 1'b0;
            roe      <= 1'b0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            if (wr && address == 3'd3) ctrl   <= writedata[6:0];
            if (wr && address == 3'd4) clkdiv <= writedata[7:0];
            if (wr && address == 3'd5) ss_reg <= writedata[NUM_SS-1:0];
            if (wr && address == 3'd2) begin
                toe <= 1'b0;
                roe <= 1'b0;
            end
            if (tx_wr && !tx_push)       toe <= 1'b1;
            if (rx_push_req && !rx_push) roe <= 1'b1;
            irq <= (tx_empty & ctrl[4]) | (~rx_empty & ctrl[5]) |
                   ((toe | roe) & ctrl[6]);
            if (rd) readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo with a slave model and RX scoreboard.
// Expected RX words are queued at push time and checked on rxdata reads.
`timescale 1ns/1ps
module tb_spi_master_fifo;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect, read_n, write_n;
    logic [2:0]  address;
    logic [15:0] writedata, readdata;
    logic        irq, sclk, mosi, miso;
    logic [0:0]  ss_n;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    // slave model / monitor state
    bit       loopback = 1'b1;
    bit       tb_cpha  = 1'b0;
    bit       tb_lsb   = 1'b0;
    logic [7:0] sword  = 8'h00;
    int       e = 0, pcnt = 0, rise_cnt = 0, k;
    logic [7:0] mo = '0;
    time      t_first, t_last, t_rise = 0, gap = 0;
    logic     ss_q = 1'b1, sclk_q = 1'b0;

    spi_master_fifo dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .address(address),
        .writedata(writedata), .readdata(readdata), .irq(irq),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    always #5 clk = ~clk;

    function automatic logic slave_bit(int ec, bit cpha, bit lsb,
                                       logic [7:0] w);
        int em, kk;
        em = ec % 16;
        kk = cpha ? ((em == 0) ? 0 : (em - 1) / 2) : em / 2;
        if (kk > 7) kk = 7;
        return w[lsb ? kk : 7 - kk];
    endfunction

    assign miso = loopback ? mosi : slave_bit(e, tb_cpha, tb_lsb, sword);

    // Edge counter, mosi capture at sampling edges, ss_n gap timing
    always @(sclk or ss_n) begin
        if (ss_n[0] !== ss_q) begin
            ss_q = ss_n[0];
            if (ss_q === 1'b0) begin
                if (rise_cnt > 0) gap = $time - t_rise;
                e = 0;
                pcnt = 0;
                mo = '0;
            end else if (ss_q === 1'b1) begin
                rise_cnt++;
                t_rise = $time;
            end
        end
        if (sclk !== sclk_q) begin
            sclk_q = sclk;
            if (ss_n[0] === 1'b0) begin
                e++;
                if (sclk === 1'b1) begin
                    if (pcnt == 0) t_first = $time;
                    t_last = $time;
                    pcnt++;
                end
                if (((e % 2) == 1) != tb_cpha) begin
                    k = ((e - 1) % 16) / 2;
                    if (tb_lsb) mo[k] = mosi;
                    else        mo[7 - k] = mosi;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    task automatic push(input logic [7:0] d, input bit track,
                        input logic [7:0] exp);
        bus_wr(3'd1, {8'h00, d});
        if (track) exp_q.push_back({8'h00, exp});
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] d, x;
        bus_rd(3'd0, d);
        x = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hdead;
        chk(tag, d, x);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic [15:0] s;
        int n = 0;
        do begin
            bus_rd(3'd2, s);
            n += 2;
        end while (!(s[4] == 1'b0 && s[0] == 1'b1) && n < budget);
        chk(tag, 16'(s[4] == 1'b0 && s[0] == 1'b1), 16'h1);
    endtask

    initial begin
        logic [15:0] d;
        int n, r0;
        reset_n = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = '0; writedata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", 16'(ss_n), 16'h1);
        chk("rst_sclk", 16'(sclk), 16'h0);
        chk("rst_mosi", 16'(mosi), 16'h0);
        chk("rst_irq", 16'(irq), 16'h0);
        chk("rst_rdata", readdata, 16'h0);
        reset_n = 1'b1;
        bus_rd(3'd2, d); chk("rst_status", d, 16'h0001);
        bus_rd(3'd6, d); chk("rst_levels", d, 16'h0000);
        bus_rd(3'd5, d); chk("rst_ss", d, 16'h0001);
        bus_rd(3'd3, d); chk("rst_ctrl", d, 16'h0000);

        // mode 0, clkdiv=1, loopback
        bus_wr(3'd4, 16'd1);
        loopback = 1'b1; tb_cpha = 1'b0; tb_lsb = 1'b0;
        push(8'hA5, 1'b1, 8'hA5);
        wait_idle("m0_done", 300);
        chk("m0_pulses", 16'(pcnt), 16'd8);
        chk("m0_period", 16'(t_last - t_first), 16'd280);
        chk("m0_mosi", {8'h00, mo}, 16'h00A5);
        bus_rd(3'd2, d); chk("m0_status", d, 16'h0005);
        pop_chk("m0_rx");
        bus_rd(3'd0, d); chk("rx_empty_read", d, 16'h0000);

        // all four modes, LSB first, slave returns 0xC3
        for (int m = 0; m < 4; m++) begin
            loopback = 1'b0; sword = 8'hC3; tb_lsb = 1'b1;
            tb_cpha = ((m >> 1) & 1) == 1;
            bus_wr(3'd3, 16'(m) | 16'h0004);
            push(8'h3C, 1'b1, 8'hC3);
            wait_idle($sformatf("mode%0d_done", m), 300);
            chk($sformatf("mode%0d_edges", m), 16'(e), 16'd16);
            chk($sformatf("mode%0d_mosi", m), {8'h00, mo}, 16'h003C);
            chk($sformatf("mode%0d_idle_sclk", m), 16'(sclk), 16'(m & 1));
            pop_chk($sformatf("mode%0d_rx", m));
        end

        // TX overflow with a slow link; first word is taken by the frame
        loopback = 1'b1; tb_cpha = 1'b0; tb_lsb = 1'b0;
        bus_wr(3'd3, 16'h0040);
        bus_wr(3'd4, 16'd255);
        for (int i = 0; i < 10; i++) push(8'(i), 1'b0, 8'h00);
        bus_rd(3'd6, d); chk("toe_levels", d, 16'h0008);
        bus_rd(3'd2, d); chk("toe_status", d, 16'h0032);
        chk("toe_irq", 16'(irq), 16'h1);
        bus_wr(3'd2, 16'h0000);
        bus_rd(3'd2, d); chk("toe_cleared", d, 16'h0012);
        @(negedge clk);
        chk("toe_irq_clr", 16'(irq), 16'h0);

        // reset in the middle of SHIFT
        n = 0;
        while (sclk !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("shift_reached", 16'(sclk), 16'h1);
        repeat (5) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_ss_n", 16'(ss_n), 16'h1);
        chk("midrst_sclk", 16'(sclk), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_rd(3'd6, d); chk("midrst_levels", d, 16'h0000);
        bus_rd(3'd2, d); chk("midrst_status", d, 16'h0001);

        // RX overflow: 9 frames, nothing read
        bus_wr(3'd3, 16'h0040);
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i), i < 8, 8'h10 + 8'(i));
        wait_idle("roe_done", 1000);
        bus_rd(3'd6, d); chk("roe_levels", d, 16'h0800);
        bus_rd(3'd2, d); chk("roe_status", d, 16'h004D);
        chk("roe_irq", 16'(irq), 16'h1);
        for (int i = 0; i < 8; i++) pop_chk($sformatf("roe_rx%0d", i));
        bus_rd(3'd2, d); chk("roe_after", d, 16'h0041);
        bus_wr(3'd2, 16'h0000);

        // SSO=1: ss_n held low across back-to-back frames
        bus_wr(3'd4, 16'd1);
        bus_wr(3'd3, 16'h0008);
        r0 = rise_cnt;
        push(8'h5A, 1'b1, 8'h5A);
        push(8'h69, 1'b1, 8'h69);
        push(8'h96, 1'b1, 8'h96);
        wait_idle("sso1_done", 600);
        chk("sso1_rises", 16'(rise_cnt - r0), 16'd0);
        chk("sso1_ss_n", 16'(ss_n), 16'h0);
        for (int i = 0; i < 3; i++) pop_chk($sformatf("sso1_rx%0d", i));

        // SSO=0: ss_n released between frames for about a half-period
        bus_wr(3'd3, 16'h0000);
        r0 = rise_cnt;
        push(8'h33, 1'b1, 8'h33);
        push(8'hCC, 1'b1, 8'hCC);
        wait_idle("sso0_done", 600);
        chk("sso0_rises", 16'(rise_cnt - r0), 16'd2);
        chk("sso0_gap", 16'(gap >= 20 && gap <= 30), 16'h1);
        pop_chk("sso0_rx0");
        pop_chk("sso0_rx1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
